// File: rtl/icache_pkg.sv
// Shared constants, request payload and helpers for the instruction cache controller.
package icache_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned LINE_WORDS     = 4;
  localparam int unsigned OFF_BITS       = 2;
  localparam int unsigned INDEX_BITS_DEF = 5;
  localparam int unsigned LINE_BASE_W    = ADDR_W - OFF_BITS - 1;

  // Controller states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_WMEM   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef logic [WORD_W-1:0]                   word_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0]   line_t;

  // Latched fetch request; the byte-select bit is dropped once legality is checked
  typedef struct packed {
    logic [ADDR_W-2:0] waddr;
    word_t             wdata;
    logic              rd;
    logic              wr;
  } req_t;

  // Byte address of a word within a line, given the line base (tag,index)
  function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_BASE_W-1:0] base,
                                                  input logic [OFF_BITS-1:0]    off);
    return {base, off, 1'b0};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational lookup, synchronous line fill and word write.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_BITS   = ADDR_W - 3 - INDEX_BITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output line_t                 o_rd_line,
  input  logic                  i_fill_en,
  input  logic [INDEX_BITS-1:0] i_fill_idx,
  input  logic [TAG_BITS-1:0]   i_fill_tag,
  input  line_t                 i_fill_line,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [OFF_BITS-1:0]   i_wr_off,
  input  word_t                 i_wr_data
);

  localparam int unsigned SETS = 32'd1 << INDEX_BITS;

  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag  [SETS];
  line_t               r_data [SETS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  // Valid bits: cleared by reset, set by a completed line fill
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  // Tag and data: whole-line fill or single-word write-hit update
  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_line;
    end else if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped write-through, no-write-allocate instruction cache controller.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int unsigned TAG_BITS = ADDR_W - 3 - INDEX_BITS;

  logic [2:0]        r_state;
  req_t              r_req;
  logic              r_hit;
  logic [2:0]        r_iss;
  logic [1:0]        r_ret;
  line_t             r_line;
  logic              r_done;
  logic              r_stall;
  logic              r_chit;
  logic              r_err;
  word_t             r_dout;
  logic [ADDR_W-1:0] r_maddr;
  logic              r_mrd;
  logic              r_mwr;
  word_t             r_mwdata;

  logic [2:0]        w_state_nxt;
  req_t              w_req_nxt;
  logic              w_hit_nxt;
  logic [2:0]        w_iss_nxt;
  logic [1:0]        w_ret_nxt;
  line_t             w_line_nxt;
  logic              w_done_nxt;
  logic              w_stall_nxt;
  logic              w_chit_nxt;
  logic              w_err_nxt;
  word_t             w_dout_nxt;
  logic [ADDR_W-1:0] w_maddr_nxt;
  logic              w_mrd_nxt;
  logic              w_mwr_nxt;
  word_t             w_mwdata_nxt;
  logic              w_fill_en;
  logic              w_wr_en;

  logic [INDEX_BITS-1:0]  w_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic [OFF_BITS-1:0]    w_off;
  logic [LINE_BASE_W-1:0] w_base;
  logic                   w_arr_valid;
  logic [TAG_BITS-1:0]    w_arr_tag;
  line_t                  w_arr_line;
  logic                   w_hit;
  logic [2:0]             w_iss_inc;

  assign w_idx     = r_req.waddr[OFF_BITS +: INDEX_BITS];
  assign w_tag     = r_req.waddr[ADDR_W-2 -: TAG_BITS];
  assign w_off     = r_req.waddr[OFF_BITS-1:0];
  assign w_base    = r_req.waddr[ADDR_W-2:OFF_BITS];
  assign w_hit     = w_arr_valid && (w_arr_tag == w_tag);
  assign w_iss_inc = r_iss + 3'd1;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_arr_valid),
    .o_rd_tag    (w_arr_tag),
    .o_rd_line   (w_arr_line),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (w_idx),
    .i_fill_tag  (w_tag),
    .i_fill_line (w_line_nxt),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_idx),
    .i_wr_off    (w_off),
    .i_wr_data   (r_req.wdata)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_hit    <= 1'b0;
      r_iss    <= '0;
      r_ret    <= '0;
      r_line   <= '0;
      r_done   <= 1'b0;
      r_stall  <= 1'b0;
      r_chit   <= 1'b0;
      r_err    <= 1'b0;
      r_dout   <= '0;
      r_maddr  <= '0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_mwdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_hit    <= w_hit_nxt;
      r_iss    <= w_iss_nxt;
      r_ret    <= w_ret_nxt;
      r_line   <= w_line_nxt;
      r_done   <= w_done_nxt;
      r_stall  <= w_stall_nxt;
      r_chit   <= w_chit_nxt;
      r_err    <= w_err_nxt;
      r_dout   <= w_dout_nxt;
      r_maddr  <= w_maddr_nxt;
      r_mrd    <= w_mrd_nxt;
      r_mwr    <= w_mwr_nxt;
      r_mwdata <= w_mwdata_nxt;
    end
  end

  // Next state and next output values; completion flags are one-cycle pulses
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_hit_nxt    = r_hit;
    w_iss_nxt    = r_iss;
    w_ret_nxt    = r_ret;
    w_line_nxt   = r_line;
    w_done_nxt   = 1'b0;
    w_stall_nxt  = 1'b0;
    w_chit_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_dout_nxt   = '0;
    w_maddr_nxt  = r_maddr;
    w_mrd_nxt    = r_mrd;
    w_mwr_nxt    = r_mwr;
    w_mwdata_nxt = r_mwdata;
    w_fill_en    = 1'b0;
    w_wr_en      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Done is visible while back in IDLE, so the still-held request is not re-taken
        if ((Rd || Wr) && !r_done) begin
          w_req_nxt.waddr = Addr[ADDR_W-1:1];
          w_req_nxt.wdata = DataIn;
          w_req_nxt.rd    = Rd;
          w_req_nxt.wr    = Wr;
          w_state_nxt     = (Addr[0] || (Rd && Wr)) ? ST_ERR : ST_LOOKUP;
        end
      end

      ST_ERR: begin
        w_done_nxt  = 1'b1;
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      ST_LOOKUP: begin
        if (r_req.rd) begin
          if (w_hit) begin
            w_done_nxt  = 1'b1;
            w_chit_nxt  = 1'b1;
            w_dout_nxt  = w_arr_line[w_off];
            w_state_nxt = ST_IDLE;
          end else begin
            w_stall_nxt = 1'b1;
            w_iss_nxt   = '0;
            w_ret_nxt   = '0;
            w_mrd_nxt   = 1'b1;
            w_maddr_nxt = word_addr(w_base, 2'd0);
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_wr_en      = w_hit;
          w_hit_nxt    = w_hit;
          w_stall_nxt  = 1'b1;
          w_mwr_nxt    = 1'b1;
          w_maddr_nxt  = {r_req.waddr, 1'b0};
          w_mwdata_nxt = r_req.wdata;
          w_state_nxt  = ST_WMEM;
        end
      end

      ST_FILL: begin
        w_stall_nxt = 1'b1;
        if (r_mrd && !mem_busy) begin
          w_iss_nxt   = w_iss_inc;
          w_mrd_nxt   = !w_iss_inc[2];
          w_maddr_nxt = word_addr(w_base, w_iss_inc[1:0]);
        end
        if (mem_rvalid) begin
          w_line_nxt[r_ret] = mem_rdata;
          w_ret_nxt         = r_ret + 2'd1;
          if (r_ret == 2'd3) begin
            w_fill_en   = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_WMEM: begin
        w_stall_nxt = 1'b1;
        if (!mem_busy) begin
          w_mwr_nxt   = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_chit_nxt  = r_req.wr && r_hit;
        w_dout_nxt  = r_req.rd ? r_line[w_off] : '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign DataOut   = r_dout;
  assign Done      = r_done;
  assign Stall     = r_stall;
  assign CacheHit  = r_chit;
  assign err       = r_err;
  assign mem_addr  = r_maddr;
  assign mem_rd    = r_mrd;
  assign mem_wr    = r_mwr;
  assign mem_wdata = r_mwdata;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a one-deep-latency backing memory model.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata  = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rd_log [$];
  logic [15:0] wa_log [$];
  logic [15:0] wd_log [$];
  logic [15:0] rq     [$];
  logic [15:0] wmem   [logic [15:0]];
  int          ret_cnt     = 0;
  int          wr_busy_cnt = 0;

  logic [15:0] t_dout;
  logic        t_hit;
  logic        t_err;
  int          t_cyc;
  logic        t_sseen;
  logic        t_sgap;
  logic        t_dstall;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_busy   (mem_busy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Initial backing memory contents
  function automatic logic [15:0] base_val(input logic [15:0] a);
    if (a == 16'h0044) return 16'hBEEF;
    return a ^ 16'h5A00;
  endfunction

  // Backing memory: accepts issues, returns reads in order one cycle later, logs traffic
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= 16'h0000;
    end else begin
      if (mem_rvalid) ret_cnt++;
      if (rq.size() > 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rq.pop_front();
      end else begin
        mem_rvalid <= 1'b0;
      end
      if (mem_rd && !mem_busy) begin
        rd_log.push_back(mem_addr);
        rq.push_back(wmem.exists(mem_addr) ? wmem[mem_addr] : base_val(mem_addr));
      end
      if (mem_wr && !mem_busy) begin
        wa_log.push_back(mem_addr);
        wd_log.push_back(mem_wdata);
        wmem[mem_addr] = mem_wdata;
      end
      if (mem_wr && mem_busy) wr_busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, hold it until Done, and capture the completion
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int busy);
    logic got = 1'b0;
    @(negedge clk);
    Addr = a; DataIn = d; Rd = rd; Wr = wr;
    mem_busy = (busy > 0);
    t_cyc = 0; t_sseen = 1'b0; t_sgap = 1'b0; t_dstall = 1'b0;
    t_dout = 16'hxxxx; t_hit = 1'bx; t_err = 1'bx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      t_cyc++;
      mem_busy = (t_cyc < busy);
      if (Done) begin
        got = 1'b1;
        t_dout = DataOut; t_hit = CacheHit; t_err = err; t_dstall = Stall;
        Rd = 1'b0; Wr = 1'b0; mem_busy = 1'b0;
      end else if (Stall) begin
        t_sseen = 1'b1;
      end else if (t_sseen) begin
        t_sgap = 1'b1;
      end
    end
    Rd = 1'b0; Wr = 1'b0; mem_busy = 1'b0;
    chk("req_done_seen", 32'(got), 1);
  endtask

  int n0;
  int w0;
  int b0;
  int c0;

  initial begin
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({Done, Stall, CacheHit, err, mem_rd, mem_wr}), 0);
    chk("rst_dout_maddr", {DataOut, mem_addr}, 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b1;
    @(negedge clk);

    // Cold read: line 0x0040 filled in order, word 0x0044 returned
    n0 = rd_log.size();
    do_req(1'b1, 1'b0, 16'h0044, 16'h0000, 0);
    chk("cold_hit", 32'(t_hit), 0);
    chk("cold_dout", 32'(t_dout), 32'hBEEF);
    chk("cold_err", 32'(t_err), 0);
    chk("cold_nrd", 32'(rd_log.size() - n0), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("cold_rd%0d", k), 32'(rd_log[n0 + k]), 32'h0040 + 32'(2 * k));
    chk("cold_stall_seen", 32'(t_sseen), 1);
    chk("cold_stall_gap", 32'(t_sgap), 0);
    chk("cold_stall_at_done", 32'(t_dstall), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(Done), 0);

    // Re-read: hit, two-cycle latency, no backing traffic, no stall
    n0 = rd_log.size();
    do_req(1'b1, 1'b0, 16'h0044, 16'h0000, 0);
    chk("hit_hit", 32'(t_hit), 1);
    chk("hit_dout", 32'(t_dout), 32'hBEEF);
    chk("hit_latency", 32'(t_cyc), 2);
    chk("hit_nrd", 32'(rd_log.size() - n0), 0);
    chk("hit_stall", 32'(t_sseen), 0);

    // Conflicting tag on same index, with issue backpressure
    n0 = rd_log.size();
    do_req(1'b1, 1'b0, 16'h0140, 16'h0000, 4);
    chk("conf_hit", 32'(t_hit), 0);
    chk("conf_dout", 32'(t_dout), 32'h5B40);
    chk("conf_nrd", 32'(rd_log.size() - n0), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("conf_rd%0d", k), 32'(rd_log[n0 + k]), 32'h0140 + 32'(2 * k));

    // Write hit held off by 3 busy cycles
    n0 = rd_log.size(); w0 = wa_log.size(); b0 = wr_busy_cnt;
    do_req(1'b0, 1'b1, 16'h0142, 16'h1234, 5);
    chk("wr_hit", 32'(t_hit), 1);
    chk("wr_dout", 32'(t_dout), 0);
    chk("wr_err", 32'(t_err), 0);
    chk("wr_latency", 32'(t_cyc), 7);
    chk("wr_nwr", 32'(wa_log.size() - w0), 1);
    chk("wr_addr", 32'(wa_log[w0]), 32'h0142);
    chk("wr_data", 32'(wd_log[w0]), 32'h1234);
    chk("wr_busy_cycles", 32'(wr_busy_cnt - b0), 3);
    chk("wr_nrd", 32'(rd_log.size() - n0), 0);

    do_req(1'b1, 1'b0, 16'h0142, 16'h0000, 0);
    chk("rewr_hit", 32'(t_hit), 1);
    chk("rewr_dout", 32'(t_dout), 32'h1234);

    // Original line was evicted by the conflicting fill
    n0 = rd_log.size();
    do_req(1'b1, 1'b0, 16'h0044, 16'h0000, 0);
    chk("evict_hit", 32'(t_hit), 0);
    chk("evict_dout", 32'(t_dout), 32'hBEEF);
    chk("evict_nrd", 32'(rd_log.size() - n0), 4);

    // Write miss goes to memory only; the following read misses and sees it
    w0 = wa_log.size();
    do_req(1'b0, 1'b1, 16'h0300, 16'hCAFE, 0);
    chk("wmiss_hit", 32'(t_hit), 0);
    chk("wmiss_nwr", 32'(wa_log.size() - w0), 1);
    do_req(1'b1, 1'b0, 16'h0300, 16'h0000, 0);
    chk("wmiss_rd_hit", 32'(t_hit), 0);
    chk("wmiss_rd_dout", 32'(t_dout), 32'hCAFE);

    // Illegal requests
    n0 = rd_log.size(); w0 = wa_log.size();
    do_req(1'b1, 1'b0, 16'h0041, 16'h0000, 0);
    chk("odd_err", 32'(t_err), 1);
    chk("odd_hit", 32'(t_hit), 0);
    chk("odd_latency", 32'(t_cyc), 2);
    do_req(1'b1, 1'b1, 16'h0040, 16'h5555, 0);
    chk("rdwr_err", 32'(t_err), 1);
    chk("err_no_mem", 32'((rd_log.size() - n0) + (wa_log.size() - w0)), 0);
    @(negedge clk);
    chk("err_clears", 32'(err), 0);

    // Reset in the middle of a fill
    c0 = ret_cnt;
    @(negedge clk);
    Addr = 16'h0080; Rd = 1'b1;
    for (int i = 0; i < 40 && (ret_cnt - c0) < 2; i++) @(negedge clk);
    chk("midfill_rets", 32'((ret_cnt - c0) >= 2), 1);
    rst = 1'b0; Rd = 1'b0;
    #1;
    chk("midrst_flags", 32'({Done, Stall, CacheHit, err, mem_rd, mem_wr}), 0);
    chk("midrst_dout_maddr", {DataOut, mem_addr}, 0);
    chk("midrst_wdata", 32'(mem_wdata), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_req(1'b1, 1'b0, 16'h0044, 16'h0000, 0);
    chk("postrst_miss", 32'(t_hit), 0);
    n0 = rd_log.size();
    do_req(1'b1, 1'b0, 16'h0080, 16'h0000, 0);
    chk("refill_hit", 32'(t_hit), 0);
    chk("refill_nrd", 32'(rd_log.size() - n0), 4);
    chk("refill_rd0", 32'(rd_log[n0]), 32'h0080);
    chk("refill_dout", 32'(t_dout), 32'h5A80);
    do_req(1'b1, 1'b0, 16'h0086, 16'h0000, 0);
    chk("refill_rehit", 32'(t_hit), 1);
    chk("refill_redout", 32'(t_dout), 32'h5A86);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Responder end of the fetch-side memory request protocol: Addr/Rd/Wr/DataIn in; DataOut/Done/Stall/CacheHit/err out.
- Direct-mapped, write-through, no-write-allocate cache with 4-word lines, in front of a pipelined word-wide backing memory.
- Fetch holds a request until Done. This block decides hit or miss, fills lines, forwards writes and flags illegal requests.

Parameters:
- INDEX_BITS, 5, set index width. SETS = 2^INDEX_BITS lines.
- TAG_BITS, 16-3-INDEX_BITS (derived; do not override), tag width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low: block resets while rst=0.
- Addr  in  16  byte address. Offset=Addr[2:1], index=Addr[3+:INDEX_BITS], tag=upper bits.
- DataIn  in  16  write data.
- Rd  in  1  read request, held until Done.
- Wr  in  1  write request, held until Done.
- DataOut  out  16  read data, valid only while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  request in progress, not yet complete.
- CacheHit  out  1  qualifies Done: request hit in cache.
- err  out  1  illegal request, valid with Done.
- mem_addr  out  16  backing memory word address.
- mem_rd  out  1  backing read issue.
- mem_wr  out  1  backing write issue.
- mem_wdata  out  16  backing write data.
- mem_busy  in  1  backing memory cannot accept an issue this cycle.
- mem_rvalid  in  1  read return strobe; returns arrive in issue order.
- mem_rdata  in  16  read return data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all valid bits cleared; issue and return counters zeroed.
  - Done, Stall, CacheHit, err, mem_rd and mem_wr are 0. DataOut, mem_addr and mem_wdata are 0.
- mem_rvalid is ignored outside FILL.
- IDLE: if Rd|Wr, latch Addr, DataIn, Rd and Wr.
  - If Addr[0]=1 or Rd&Wr, go to ERR.
  - Otherwise go to LOOKUP.
  - Stall=0 in IDLE.
- ERR: Done=1, err=1, CacheHit=0, Stall=0 for one cycle; no backing access; then IDLE.
- LOOKUP: hit = valid[idx] & tag match.
  - Read hit: Done=1, CacheHit=1, DataOut=line word at offset, Stall=0; then IDLE. Total latency is 2 cycles from request.
  - Read miss: Stall=1; go to FILL.
  - Write, hit or miss: if hit, write DataIn into the cached word this cycle. Record hit. Stall=1; go to WMEM.
- FILL: issue 4 reads to {tag,idx,offset,0} for offsets 0,1,2,3, in order.
  - An issue happens on a cycle with mem_rd=1 and mem_busy=0; mem_rd stays high until all 4 are issued.
  - A 2-bit counter captures returns into the line buffer.
  - After the 4th return, write data/tag/valid to the array and go to DONE.
  - Stall=1 throughout.
- WMEM: mem_wr=1, mem_addr={Addr[15:1],0}, mem_wdata=DataIn until a cycle with mem_busy=0; then DONE. Stall=1.
- DONE: Done=1 for one cycle, Stall=0.
  - CacheHit=0 after a fill; equals the recorded hit after a write.
  - DataOut holds the requested word after a read; 0 after a write.
  - Then IDLE.
- A new request is sampled in IDLE only, so there is at least one idle cycle between requests.
- Eviction: a fill overwrites its index unconditionally (write-through, so no writeback).
- Rd/Wr dropped before Done: the latched request still completes; later Rd/Wr are ignored until IDLE.
- Reset mid-FILL or mid-WMEM: aborts the operation; the partial line is never marked valid. Backing memory shares rst, so no stale returns survive reset.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, LOOKUP, FILL, WMEM, DONE, ERR};
  - LINE_WORDS=4; WORD_W=16; address field widths and slicing functions.
- One sub-module, icache_array:
  - SETS-entry tag/valid/data storage with combinational read and synchronous line-fill and word-write ports;
  - valid bits cleared by async reset.

Test Plan:
- Reset: hold rst=0 mid-traffic -> all outputs 0 and valid cleared; the first read after release misses.
- Cold read at 0x0040, backing memory word at 0x0044=0xBEEF, mem_busy=0:
  - mem_rd issues 0x0040, 0x0042, 0x0044, 0x0046;
  - Done=1, CacheHit=0, DataOut=0xBEEF;
  - Stall=1 from LOOKUP until DONE.
- Re-read 0x0044 -> Done 2 cycles after Rd, CacheHit=1, DataOut=0xBEEF, no mem_rd, Stall never 1.
- Conflict: read 0x0140 (same index, tag 0x01) -> miss and fill; then read 0x0044 -> CacheHit=0 (evicted).
- Write 0x1234 to 0x0142 after 0x0140 is filled:
  - mem_wr to 0x0142 with data 0x1234, held through 3 mem_busy cycles;
  - Done with CacheHit=1;
  - re-read 0x0142 -> hit, 0x1234.
- Errors: Rd at 0x0041 -> Done=1, err=1, no mem_rd. Rd=Wr=1 -> same. Reset pulse after the 2nd fill return, then read the same address -> full 4-word refill.
